mipi_csi_raw10_depacker: RTL and testbench

MIPI_CSI_RAW10_DEPACKER -- requirements
Module: mipi_csi_raw10_depacker

---
 rtl/mipi_csi_pkg.sv | 8 +
 rtl/mipi_csi_raw10_unpack.sv | 12 +
 rtl/mipi_csi_raw10_depacker.sv | 73 +++++++
 tb/tb_mipi_csi_raw10_depacker.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mipi_csi_pkg.sv
// mipi_csi_pkg: shared packet-type code, RAW10 geometry and pixel group type
// for the MIPI CSI-2 receive datapath.
package mipi_csi_pkg;
    localparam logic [2:0] PKT_TYPE_RAW10    = 3'd3;
    localparam int         RAW10_GROUP_BYTES = 5;
    localparam int         PIXEL_W           = 10;
    typedef logic [4*PIXEL_W-1:0] pixel4_t;
endpackage

// File: rtl/mipi_csi_raw10_unpack.sv
// mipi_csi_raw10_unpack: maps one 5-byte RAW10 group to four 10-bit pixels.
module mipi_csi_raw10_unpack
    import mipi_csi_pkg::*;
(
    input  logic [8*RAW10_GROUP_BYTES-1:0] raw,
    output pixel4_t                        pix
);
    // Byte 4 carries the two LSBs of every pixel, P0 in its lowest bits.
    for (genvar n = 0; n < 4; n++) begin : g_pix
        assign pix[PIXEL_W*n +: PIXEL_W] = {raw[8*n +: 8], raw[32+2*n +: 2]};
    end
endmodule

// File: rtl/mipi_csi_raw10_depacker.sv
// mipi_csi_raw10_depacker: accumulates 32-bit CSI payload words and emits RAW10 4-pixel groups.
// Optional sticky length-error flag len_err_o when MIPI_CSI_RAW10_LEN_ERR_EN is defined.
module mipi_csi_raw10_depacker
    import mipi_csi_pkg::*;
(
    input  logic          clk_i,
    input  logic          reset_n_i,
    input  logic          data_valid_i,
    input  logic [31:0]   data_i,
    input  logic [2:0]    packet_type_i,
    output logic          output_valid_o,
    output pixel4_t       pixel_data_o,
    output logic          line_end_o
`ifdef MIPI_CSI_RAW10_LEN_ERR_EN
    ,
    output logic          len_err_o
`endif
);
    logic [2:0]  cnt;
    logic [63:0] byte_buf;
    logic [63:0] acc;
    logic        prev_valid;
    logic        armed;
    logic        accept;
    logic        emit;
    pixel4_t     pix;

    // Unused upper bytes of byte_buf are kept zero, so new bytes can simply be OR-ed in.
    always_comb begin
        acc    = byte_buf | ({32'd0, data_i} << {cnt, 3'b000});
        accept = data_valid_i && armed && packet_type_i == PKT_TYPE_RAW10;
        emit   = accept && cnt != 3'd0;
    end

    mipi_csi_raw10_unpack u_unpack (
        .raw (acc[8*RAW10_GROUP_BYTES-1:0]),
        .pix (pix)
    );

    // armed stays low after reset until data_valid_i has been seen low, so a
    // packet interrupted by reset is never resumed mid-stream.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt            <= 3'd0;
            byte_buf       <= 64'd0;
            prev_valid     <= 1'b0;
            armed          <= 1'b0;
            output_valid_o <= 1'b0;
            pixel_data_o   <= '0;
            line_end_o     <= 1'b0;
        end else begin
            prev_valid     <= data_valid_i;
            line_end_o     <= prev_valid && !data_valid_i;
            output_valid_o <= emit;
            if (emit) pixel_data_o <= pix;
            if (!data_valid_i) begin
                armed    <= 1'b1;
                cnt      <= 3'd0;
                byte_buf <= 64'd0;
            end else if (accept) begin
                cnt      <= emit ? cnt - 3'd1 : 3'd4;
                byte_buf <= emit ? acc >> (8*RAW10_GROUP_BYTES) : acc;
            end
        end
    end

`ifdef MIPI_CSI_RAW10_LEN_ERR_EN
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) len_err_o <= 1'b0;
        else if (prev_valid && !data_valid_i && cnt != 3'd0) len_err_o <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_mipi_csi_raw10_depacker.sv
// tb_mipi_csi_raw10_depacker: table-driven plus hand-written sequences, with a
// byte-queue reference model feeding an expected-group scoreboard.
module tb_mipi_csi_raw10_depacker;
    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        data_valid_i = 1'b0;
    logic [31:0] data_i = 32'd0;
    logic [2:0]  packet_type_i = 3'd0;
    logic        output_valid_o;
    logic [39:0] pixel_data_o;
    logic        line_end_o;
`ifdef MIPI_CSI_RAW10_LEN_ERR_EN
    logic        len_err_o;
`endif

    mipi_csi_raw10_depacker dut (
        .clk_i          (clk_i),
        .reset_n_i      (reset_n_i),
        .data_valid_i   (data_valid_i),
        .data_i         (data_i),
        .packet_type_i  (packet_type_i),
        .output_valid_o (output_valid_o),
        .pixel_data_o   (pixel_data_o),
        .line_end_o     (line_end_o)
`ifdef MIPI_CSI_RAW10_LEN_ERR_EN
        ,
        .len_err_o      (len_err_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic [2:0]  t;
        logic        exp_ov;
        logic        exp_le;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    int          groups = 0;
    int          line_ends = 0;
    logic [7:0]  bq[$];
    logic [39:0] exp_q[$];
    logic        exp_now = 1'b0;
    logic [39:0] last_pix = 40'd0;
    vec_t        tbl[22];

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] unpack_ref(input logic [7:0] b[5]);
        logic [39:0] p;
        logic [7:0]  lsb;
        lsb = b[4];
        for (int n = 0; n < 4; n++) p[10*n +: 10] = {b[n], lsb[2*n +: 2]};
        return p;
    endfunction

    task automatic model(input logic v, input logic [31:0] d, input logic [2:0] t);
        logic [7:0] g[5];
        exp_now = 1'b0;
        if (!v) bq.delete();
        else if (t == 3'd3) begin
            for (int i = 0; i < 4; i++) bq.push_back(d[8*i +: 8]);
            if (bq.size() >= 5) begin
                for (int i = 0; i < 5; i++) g[i] = bq.pop_front();
                exp_q.push_back(unpack_ref(g));
                exp_now = 1'b1;
            end
        end
    endtask

    task automatic sample();
        chk("valid_vs_model", {39'd0, output_valid_o}, {39'd0, exp_now});
        if (output_valid_o) begin
            groups++;
            if (exp_q.size() == 0) chk("unexpected_group", 40'd1, 40'd0);
            else chk("pixel_data", pixel_data_o, exp_q.pop_front());
        end else begin
            chk("pixel_hold", pixel_data_o, last_pix);
        end
        last_pix = pixel_data_o;
        if (line_end_o) line_ends++;
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic [2:0] t);
        data_valid_i  = v;
        data_i        = d;
        packet_type_i = t;
        model(v, d, t);
        @(posedge clk_i);
        #1;
        sample();
        @(negedge clk_i);
    endtask

    initial begin
        logic [39:0] req026;
        int g0;
        int l0;
        req026 = {10'h113, 10'h0CE, 10'h089, 10'h044};
        tbl[0]  = '{1'b0, 32'h0,        3'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 32'h44332211, 3'd3, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 32'h000000E4, 3'd3, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 32'h0,        3'd0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 32'hA1B2C3D4, 3'd3, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 32'h5F6E7D8C, 3'd3, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 32'h01234567, 3'd3, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 32'h89ABCDEF, 3'd3, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 32'hFEDCBA98, 3'd3, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 32'h0,        3'd0, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 32'h0,        3'd0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 32'h11112222, 3'd3, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 32'h33334444, 3'd3, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 32'h55556666, 3'd3, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 32'h0,        3'd0, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 32'h0,        3'd0, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 32'hDEADBEEF, 3'd1, 1'b0, 1'b0};
        tbl[17] = '{1'b1, 32'hCAFEF00D, 3'd1, 1'b0, 1'b0};
        tbl[18] = '{1'b1, 32'h76543210, 3'd3, 1'b0, 1'b0};
        tbl[19] = '{1'b1, 32'hFFFFFFFF, 3'd2, 1'b0, 1'b0};
        tbl[20] = '{1'b1, 32'h000000FF, 3'd3, 1'b1, 1'b0};
        tbl[21] = '{1'b0, 32'h0,        3'd0, 1'b0, 1'b1};

        #1;
        chk("reset_valid", {39'd0, output_valid_o}, 40'd0);
        chk("reset_pixel", pixel_data_o, 40'd0);
        chk("reset_line_end", {39'd0, line_end_o}, 40'd0);
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;
        @(negedge clk_i);

        for (int i = 0; i < 22; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].t);
            chk($sformatf("tbl%0d_valid", i), {39'd0, output_valid_o}, {39'd0, tbl[i].exp_ov});
            chk($sformatf("tbl%0d_line_end", i), {39'd0, line_end_o}, {39'd0, tbl[i].exp_le});
            if (i == 2) chk("raw10_first_group", pixel_data_o, req026);
        end
`ifdef MIPI_CSI_RAW10_LEN_ERR_EN
        chk("len_err_set", {39'd0, len_err_o}, 40'd1);
`endif

        // Reset mid-packet, then a fresh packet must depack with no stale bytes.
        step(1'b1, 32'h13579BDF, 3'd3);
        step(1'b1, 32'h2468ACE0, 3'd3);
        step(1'b1, 32'h0F1E2D3C, 3'd3);
        reset_n_i    = 1'b0;
        data_valid_i = 1'b0;
        #1;
        chk("async_reset_valid", {39'd0, output_valid_o}, 40'd0);
        chk("async_reset_pixel", pixel_data_o, 40'd0);
        chk("async_reset_line_end", {39'd0, line_end_o}, 40'd0);
`ifdef MIPI_CSI_RAW10_LEN_ERR_EN
        chk("async_reset_len_err", {39'd0, len_err_o}, 40'd0);
`endif
        bq.delete();
        exp_q.delete();
        last_pix = 40'd0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        step(1'b0, 32'h0, 3'd0);
        g0 = groups;
        for (int i = 0; i < 5; i++) step(1'b1, 32'h9A000000 | (32'(i) * 32'h00010203), 3'd3);
        step(1'b0, 32'h0, 3'd0);
        chk("post_reset_groups", 40'(groups - g0), 40'd4);

        // Two packets separated by a single idle cycle stay independent.
        g0 = groups;
        l0 = line_ends;
        for (int i = 0; i < 5; i++) step(1'b1, 32'h10203040 + 32'(i), 3'd3);
        step(1'b0, 32'h0, 3'd0);
        for (int i = 0; i < 5; i++) step(1'b1, 32'hF0E0D0C0 - 32'(i), 3'd3);
        step(1'b0, 32'h0, 3'd0);
        step(1'b0, 32'h0, 3'd0);
        chk("b2b_groups", 40'(groups - g0), 40'd8);
        chk("b2b_line_ends", 40'(line_ends - l0), 40'd2);
        chk("scoreboard_drained", 40'(exp_q.size()), 40'd0);
`ifdef MIPI_CSI_RAW10_LEN_ERR_EN
        chk("len_err_clean", {39'd0, len_err_o}, 40'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
